// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary for the RV32I 5-stage core.
// Registers decoded operands/control into E, detects load-use hazards,
// inserts bubbles on load-use stalls and taken branches, and keeps
// saturating stall/flush performance counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validD,
  input  logic [XLEN-1:0] pcD,
  input  logic [XLEN-1:0] rdata1D,
  input  logic [XLEN-1:0] rdata2D,
  input  logic [XLEN-1:0] immD,
  input  logic [4:0]      raddr1D,
  input  logic [4:0]      raddr2D,
  input  logic [4:0]      waddrD,
  input  logic            reg_wrD,
  input  logic [1:0]      wb_selD,
  input  logic            mem_wrD,
  input  logic [3:0]      alu_opD,
  input  logic [2:0]      br_typeD,
  input  logic            sel_AD,
  input  logic            sel_BD,
  input  logic            br_takenE,
  output logic            validE,
  output logic [XLEN-1:0] pcE,
  output logic [XLEN-1:0] rdata1E,
  output logic [XLEN-1:0] rdata2E,
  output logic [XLEN-1:0] immE,
  output logic [4:0]      raddr1E,
  output logic [4:0]      raddr2E,
  output logic [4:0]      waddrE,
  output logic            reg_wrE,
  output logic [1:0]      wb_selE,
  output logic            mem_wrE,
  output logic [3:0]      alu_opE,
  output logic [2:0]      br_typeE,
  output logic            sel_AE,
  output logic            sel_BE,
  output logic            stallF,
  output logic            stallD,
  output logic            flushD,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] WB_LOAD = 2'b10;

  logic             r_validE;
  logic [XLEN-1:0]  r_pcE, r_rdata1E, r_rdata2E, r_immE;
  logic [4:0]       r_raddr1E, r_raddr2E, r_waddrE;
  logic             r_reg_wrE, r_mem_wrE, r_sel_AE, r_sel_BE;
  logic [1:0]       r_wb_selE;
  logic [3:0]       r_alu_opE;
  logic [2:0]       r_br_typeE;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_lw_stall;
  logic w_bubble;
  logic w_stall;

  // Load in E whose destination is read by a valid D instruction; x0 never hazards.
  assign w_lw_stall = r_validE & r_reg_wrE & (r_wb_selE == WB_LOAD) & (r_waddrE != 5'd0) &
                      validD & ((raddr1D == r_waddrE) | (raddr2D == r_waddrE));
  // A taken branch discards the D instruction, so it cancels any stall.
  assign w_stall  = w_lw_stall & ~br_takenE;
  assign w_bubble = br_takenE | w_lw_stall;

  assign stallF = w_stall;
  assign stallD = w_stall;
  assign flushD = br_takenE;

  // E-stage register: bubble on flush or load-use, otherwise capture D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_bubble) begin
      r_validE   <= 1'b0;
      r_pcE      <= '0;
      r_rdata1E  <= '0;
      r_rdata2E  <= '0;
      r_immE     <= '0;
      r_raddr1E  <= '0;
      r_raddr2E  <= '0;
      r_waddrE   <= '0;
      r_reg_wrE  <= 1'b0;
      r_wb_selE  <= '0;
      r_mem_wrE  <= 1'b0;
      r_alu_opE  <= '0;
      r_br_typeE <= '0;
      r_sel_AE   <= 1'b0;
      r_sel_BE   <= 1'b0;
    end else begin
      r_validE   <= validD;
      r_pcE      <= pcD;
      r_rdata1E  <= rdata1D;
      r_rdata2E  <= rdata2D;
      r_immE     <= immD;
      r_raddr1E  <= raddr1D;
      r_raddr2E  <= raddr2D;
      r_waddrE   <= waddrD;
      r_reg_wrE  <= reg_wrD & validD;
      r_wb_selE  <= wb_selD;
      r_mem_wrE  <= mem_wrD & validD;
      r_alu_opE  <= alu_opD;
      r_br_typeE <= br_typeD;
      r_sel_AE   <= sel_AD;
      r_sel_BE   <= sel_BD;
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (br_takenE && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign validE    = r_validE;
  assign pcE       = r_pcE;
  assign rdata1E   = r_rdata1E;
  assign rdata2E   = r_rdata2E;
  assign immE      = r_immE;
  assign raddr1E   = r_raddr1E;
  assign raddr2E   = r_raddr2E;
  assign waddrE    = r_waddrE;
  assign reg_wrE   = r_reg_wrE;
  assign wb_selE   = r_wb_selE;
  assign mem_wrE   = r_mem_wrE;
  assign alu_opE   = r_alu_opE;
  assign br_typeE  = r_br_typeE;
  assign sel_AE    = r_sel_AE;
  assign sel_BE    = r_sel_BE;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic checked against an instruction-level reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic        rw;
    logic [1:0]  wb;
    logic        mw;
    logic [3:0]  op;
    logic [2:0]  bt;
    logic        sa;
    logic        sb;
  } e_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  e_t   d   = '0;
  logic br  = 1'b0;

  always #5 clk = ~clk;

  // main DUT outputs
  logic        validE, reg_wrE, mem_wrE, sel_AE, sel_BE, stallF, stallD, flushD;
  logic [31:0] pcE, rdata1E, rdata2E, immE, stall_cnt, flush_cnt;
  logic [4:0]  raddr1E, raddr2E, waddrE;
  logic [1:0]  wb_selE;
  logic [3:0]  alu_opE;
  logic [2:0]  br_typeE;
  // 4-bit counter DUT outputs
  logic        s_validE, s_reg_wrE, s_mem_wrE, s_sel_AE, s_sel_BE, s_stallF, s_stallD, s_flushD;
  logic [31:0] s_pcE, s_rdata1E, s_rdata2E, s_immE;
  logic [3:0]  s_stall_cnt, s_flush_cnt;
  logic [4:0]  s_raddr1E, s_raddr2E, s_waddrE;
  logic [1:0]  s_wb_selE;
  logic [3:0]  s_alu_opE;
  logic [2:0]  s_br_typeE;

  id_ex_stage #(.XLEN(32), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .validD(d.valid), .pcD(d.pc), .rdata1D(d.rd1), .rdata2D(d.rd2),
    .immD(d.imm), .raddr1D(d.ra1), .raddr2D(d.ra2), .waddrD(d.wa), .reg_wrD(d.rw),
    .wb_selD(d.wb), .mem_wrD(d.mw), .alu_opD(d.op), .br_typeD(d.bt), .sel_AD(d.sa),
    .sel_BD(d.sb), .br_takenE(br),
    .validE(validE), .pcE(pcE), .rdata1E(rdata1E), .rdata2E(rdata2E), .immE(immE),
    .raddr1E(raddr1E), .raddr2E(raddr2E), .waddrE(waddrE), .reg_wrE(reg_wrE),
    .wb_selE(wb_selE), .mem_wrE(mem_wrE), .alu_opE(alu_opE), .br_typeE(br_typeE),
    .sel_AE(sel_AE), .sel_BE(sel_BE), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .validD(d.valid), .pcD(d.pc), .rdata1D(d.rd1), .rdata2D(d.rd2),
    .immD(d.imm), .raddr1D(d.ra1), .raddr2D(d.ra2), .waddrD(d.wa), .reg_wrD(d.rw),
    .wb_selD(d.wb), .mem_wrD(d.mw), .alu_opD(d.op), .br_typeD(d.bt), .sel_AD(d.sa),
    .sel_BD(d.sb), .br_takenE(br),
    .validE(s_validE), .pcE(s_pcE), .rdata1E(s_rdata1E), .rdata2E(s_rdata2E), .immE(s_immE),
    .raddr1E(s_raddr1E), .raddr2E(s_raddr2E), .waddrE(s_waddrE), .reg_wrE(s_reg_wrE),
    .wb_selE(s_wb_selE), .mem_wrE(s_mem_wrE), .alu_opE(s_alu_opE), .br_typeE(s_br_typeE),
    .sel_AE(s_sel_AE), .sel_BE(s_sel_BE), .stallF(s_stallF), .stallD(s_stallD),
    .flushD(s_flushD), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  e_t dut_e;
  assign dut_e = {validE, pcE, rdata1E, rdata2E, immE, raddr1E, raddr2E, waddrE,
                  reg_wrE, wb_selE, mem_wrE, alu_opE, br_typeE, sel_AE, sel_BE};

  // reference model: the instruction sitting in E plus event counts
  e_t          me;
  int unsigned m_stall, m_flush;
  int unsigned m_sstall, m_sflush;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic m_hazard(e_t e, e_t dd);
    return e.valid && e.rw && e.wb == 2'b10 && e.wa != 5'd0 && dd.valid &&
           (dd.ra1 == e.wa || dd.ra2 == e.wa);
  endfunction

  function automatic logic m_stall_now();
    return m_hazard(me, d) && !br;
  endfunction

  task automatic model_reset();
    me = '0; m_stall = 0; m_flush = 0; m_sstall = 0; m_sflush = 0;
  endtask

  // Advance one clock; model computes its next state from pre-edge inputs.
  task automatic step();
    logic hz, st;
    hz = m_hazard(me, d);
    st = hz && !br;
    @(posedge clk);
    if (st) begin
      m_stall++;
      if (m_sstall < 15) m_sstall++;
    end
    if (br) begin
      m_flush++;
      if (m_sflush < 15) m_sflush++;
    end
    if (br || hz) me = '0;
    else begin
      me = d;
      if (!d.valid) begin me.rw = 1'b0; me.mw = 1'b0; end
    end
    #1;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
  endtask

  function automatic e_t mk(logic [31:0] pc, logic [4:0] r1, logic [4:0] r2,
                            logic [4:0] w, logic rw, logic [1:0] wb);
    e_t t;
    t = '0;
    t.valid = 1'b1; t.pc = pc; t.ra1 = r1; t.ra2 = r2; t.wa = w; t.rw = rw; t.wb = wb;
    t.rd1 = 32'hA000_0000 | pc; t.rd2 = 32'hB000_0000 | pc; t.imm = 32'h10; t.op = 4'h3;
    return t;
  endfunction

  task automatic test_reset();
    #3;
    n_chk++;
    if (dut_e !== '0 || stallD !== 1'b0 || stallF !== 1'b0 || flushD !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got e=%h st=%b fl=%b, want all zero", dut_e, stallD, flushD);
    end
    n_chk++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d, want 0/0", stall_cnt, flush_cnt);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_normal();
    do_reset();
    d = mk(32'h100, 5'd5, 5'd0, 5'd7, 1'b1, 2'b00);
    step();
    n_chk++;
    if (pcE !== 32'h100 || raddr1E !== 5'd5 || waddrE !== 5'd7 || validE !== 1'b1) begin
      n_fail++;
      $display("FAIL normal_capture: got pc=%h ra1=%0d wa=%0d v=%b, want 100/5/7/1",
               pcE, raddr1E, waddrE, validE);
    end
    n_chk++;
    if (dut_e !== me || stallD !== 1'b0 || flushD !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_full: got e=%h st=%b fl=%b, want e=%h st=0 fl=0", dut_e, stallD, flushD, me);
    end
  endtask

  task automatic test_load_use();
    e_t cons;
    do_reset();
    d = mk(32'h200, 5'd1, 5'd2, 5'd6, 1'b1, 2'b10);
    step();
    cons = mk(32'h204, 5'd3, 5'd6, 5'd8, 1'b1, 2'b00);
    d = cons;
    #1;
    n_chk++;
    if (stallD !== 1'b1 || stallF !== 1'b1 || flushD !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_stall: got stF=%b stD=%b fl=%b, want 1/1/0", stallF, stallD, flushD);
    end
    step();
    n_chk++;
    if (validE !== 1'b0 || raddr1E !== 5'd0 || raddr2E !== 5'd0 || dut_e !== '0) begin
      n_fail++;
      $display("FAIL lu_bubble: got e=%h, want zero", dut_e);
    end
    n_chk++;
    if (stall_cnt !== 32'd1 || stallD !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_count: got cnt=%0d stD=%b, want 1/0", stall_cnt, stallD);
    end
    step();
    n_chk++;
    if (dut_e !== cons) begin
      n_fail++;
      $display("FAIL lu_replay: got e=%h, want %h", dut_e, cons);
    end
  endtask

  task automatic test_load_x0();
    e_t t;
    do_reset();
    d = mk(32'h300, 5'd1, 5'd2, 5'd0, 1'b1, 2'b10);
    step();
    d = mk(32'h304, 5'd0, 5'd4, 5'd9, 1'b1, 2'b00);
    #1;
    n_chk++;
    if (stallD !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_no_stall: got stD=%b, want 0", stallD);
    end
    d = mk(32'h308, 5'd1, 5'd2, 5'd6, 1'b1, 2'b10);
    step();
    t = mk(32'h30C, 5'd4, 5'd6, 5'd9, 1'b1, 2'b00);
    t.valid = 1'b0; t.mw = 1'b1;
    d = t;
    #1;
    n_chk++;
    if (stallD !== 1'b0) begin
      n_fail++;
      $display("FAIL invalidD_no_stall: got stD=%b, want 0", stallD);
    end
    step();
    n_chk++;
    if (validE !== 1'b0 || reg_wrE !== 1'b0 || mem_wrE !== 1'b0 || pcE !== 32'h30C) begin
      n_fail++;
      $display("FAIL invalidD_capture: got v=%b rw=%b mw=%b pc=%h, want 0/0/0/30c",
               validE, reg_wrE, mem_wrE, pcE);
    end
  endtask

  task automatic test_branch_lu();
    do_reset();
    d = mk(32'h400, 5'd1, 5'd2, 5'd6, 1'b1, 2'b10);
    step();
    d = mk(32'h404, 5'd6, 5'd2, 5'd8, 1'b1, 2'b00);
    br = 1'b1;
    #1;
    n_chk++;
    if (stallD !== 1'b0 || stallF !== 1'b0 || flushD !== 1'b1) begin
      n_fail++;
      $display("FAIL br_lu_ctrl: got stD=%b stF=%b fl=%b, want 0/0/1", stallD, stallF, flushD);
    end
    step();
    br = 1'b0;
    n_chk++;
    if (dut_e !== '0 || flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL br_lu_state: got e=%h fc=%0d sc=%0d, want 0/1/0", dut_e, flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    e_t cons;
    do_reset();
    d = mk(32'h500, 5'd1, 5'd2, 5'd6, 1'b1, 2'b10);
    step();
    cons = mk(32'h504, 5'd6, 5'd6, 5'd8, 1'b1, 2'b00);
    d = cons;
    #1;
    n_chk++;
    if (stallD !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got stD=%b, want 1", stallD);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (dut_e !== '0 || stallD !== 1'b0 || stallF !== 1'b0 || stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_async: got e=%h stD=%b sc=%0d, want all zero", dut_e, stallD, stall_cnt);
    end
    #1 rst = 1'b0;
    model_reset();
    step();
    n_chk++;
    if (dut_e !== cons) begin
      n_fail++;
      $display("FAIL mid_resume: got e=%h, want %h", dut_e, cons);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    // self-dependent load: stalls on every other cycle
    d = mk(32'h600, 5'd6, 5'd1, 5'd6, 1'b1, 2'b10);
    for (int i = 0; i < 40; i++) step();
    n_chk++;
    if (s_stall_cnt !== 4'hF) begin
      n_fail++;
      $display("FAIL sat_stall4: got %h, want f", s_stall_cnt);
    end
    n_chk++;
    if (stall_cnt !== 32'd20) begin
      n_fail++;
      $display("FAIL sat_stall32: got %0d, want 20", stall_cnt);
    end
    for (int i = 0; i < 20; i++) begin br = 1'b1; step(); end
    br = 1'b0;
    n_chk++;
    if (s_flush_cnt !== 4'hF || flush_cnt !== 32'd20) begin
      n_fail++;
      $display("FAIL sat_flush: got %h/%0d, want f/20", s_flush_cnt, flush_cnt);
    end
  endtask

  task automatic test_random();
    e_t t;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      t.valid = ($urandom_range(0, 9) != 0);
      t.pc  = $urandom; t.rd1 = $urandom; t.rd2 = $urandom; t.imm = $urandom;
      t.ra1 = 5'($urandom_range(0, 3)); t.ra2 = 5'($urandom_range(0, 3));
      t.wa  = 5'($urandom_range(0, 3));
      t.rw  = ($urandom_range(0, 4) != 0);
      t.wb  = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
      t.mw  = 1'($urandom); t.op = 4'($urandom); t.bt = 3'($urandom);
      t.sa  = 1'($urandom); t.sb = 1'($urandom);
      d  = t;
      br = ($urandom_range(0, 6) == 0);
      #1;
      n_chk++;
      if (stallD !== m_stall_now() || stallF !== m_stall_now() || flushD !== br) begin
        n_fail++;
        $display("FAIL rnd_ctrl[%0d]: got stD=%b stF=%b fl=%b, want %b/%b/%b",
                 i, stallD, stallF, flushD, m_stall_now(), m_stall_now(), br);
      end
      step();
      n_chk++;
      if (dut_e !== me) begin
        n_fail++;
        $display("FAIL rnd_e[%0d]: got %h, want %h", i, dut_e, me);
      end
      n_chk++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush ||
          s_stall_cnt !== 4'(m_sstall) || s_flush_cnt !== 4'(m_sflush)) begin
        n_fail++;
        $display("FAIL rnd_cnt[%0d]: got %0d/%0d/%0d/%0d, want %0d/%0d/%0d/%0d", i,
                 stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt, m_stall, m_flush, m_sstall, m_sflush);
      end
    end
    br = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_load_use();
    test_load_x0();
    test_branch_lu();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
